// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG ingress flow controller.
// State encodings are visible on the debug port, so their values are fixed.
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FAIL    = 3'd4
    } state_t;

    localparam int DEF_WORD_W      = 32;
    localparam int DEF_WARMUP_BITS = 64;
    localparam int DEF_RCT_LIMIT   = 34;
    localparam int DEF_CNT_W       = 16;
    localparam int RUN_W           = 16;

    // Raw bits only feed the packer and the health test in these two states.
    function automatic logic isActive(input state_t s);
        return (s == ST_WARMUP) || (s == ST_COLLECT);
    endfunction

endpackage

// File: rtl/trng_rct_monitor.sv
// Repetition-count health test: tracks the last raw bit and the length of the current run.
// The trip output is combinational so the controller can react on the offending bit itself.
module trng_rct_monitor
    import trng_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_bit,
    input  logic             i_valid,
    input  logic             i_clr,
    input  logic [RUN_W-1:0] i_limit,
    output logic             o_trip
);

    logic             r_lastBit;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_runNext;

    // A zero run means no bit has been seen since the last clear; the counter saturates.
    always_comb begin
        w_runNext = RUN_W'(1);
        if ((r_run != '0) && (i_bit == r_lastBit)) begin
            w_runNext = (r_run == '1) ? r_run : r_run + 1'b1;
        end
    end

    assign o_trip = i_valid && (w_runNext >= i_limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run     <= '0;
            r_lastBit <= 1'b0;
        end else if (i_clr) begin
            r_run     <= '0;
            r_lastBit <= 1'b0;
        end else if (i_valid) begin
            r_run     <= w_runNext;
            r_lastBit <= i_bit;
        end
    end

endmodule

// File: rtl/trng_flow_ctrl.sv
// TRNG-to-FIFO1 ingress sequencer: gates the core, discards warm-up bits, packs words,
// runs the repetition-count health test and writes words to FIFO1 under back-pressure.
module trng_flow_ctrl
    import trng_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int WARMUP_BITS = DEF_WARMUP_BITS,
    parameter int RCT_LIMIT   = DEF_RCT_LIMIT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_enable,
    input  logic              i_clear_fail,
    input  logic              i_trng_bit,
    input  logic              i_trng_bit_valid,
    output logic              o_trng_en,
    input  logic              i_fifo_full,
    output logic              o_fifo_wr_en,
    output logic [WORD_W-1:0] o_fifo_wr_data,
    output logic              o_health_fail,
    output logic [CNT_W-1:0]  o_word_count,
    output logic [2:0]        o_state
);

    localparam int WU_W  = $clog2(WARMUP_BITS + 1);
    localparam int BIT_W = $clog2(WORD_W + 1);

    state_t            r_state;
    logic [WU_W-1:0]   r_wuCnt;
    logic [BIT_W-1:0]  r_bitCnt;
    logic [WORD_W-1:0] r_shreg;
    logic              r_trngEn;
    logic              r_healthFail;
    logic [CNT_W-1:0]  r_wordCount;

    logic w_bitIn;
    logic w_rctClr;
    logic w_trip;
    logic w_wuLast;
    logic w_wordLast;
    logic w_wrAccept;

    assign w_bitIn    = i_trng_bit_valid && isActive(r_state);
    assign w_rctClr   = ((r_state == ST_IDLE) && i_enable) ||
                        ((r_state == ST_FAIL) && i_clear_fail);
    assign w_wuLast   = (r_wuCnt == WU_W'(WARMUP_BITS - 1));
    assign w_wordLast = (r_bitCnt == BIT_W'(WORD_W - 1));
    assign w_wrAccept = (r_state == ST_WRITE) && !i_fifo_full;

    trng_rct_monitor u_rct (
        .clk     (clk),
        .rst     (rst),
        .i_bit   (i_trng_bit),
        .i_valid (w_bitIn),
        .i_clr   (w_rctClr),
        .i_limit (RUN_W'(RCT_LIMIT)),
        .o_trip  (w_trip)
    );

    // Each branch orders its checks as: health trip, then completion, then enable drop.
    // trng_en is set alongside every transition so it always matches the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wuCnt      <= '0;
            r_bitCnt     <= '0;
            r_shreg      <= '0;
            r_trngEn     <= 1'b0;
            r_healthFail <= 1'b0;
            r_wordCount  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_enable) begin
                        r_state  <= ST_WARMUP;
                        r_wuCnt  <= '0;
                        r_bitCnt <= '0;
                        r_trngEn <= 1'b1;
                    end
                end
                ST_WARMUP: begin
                    if (w_trip) begin
                        r_state      <= ST_FAIL;
                        r_healthFail <= 1'b1;
                        r_trngEn     <= 1'b0;
                    end else if (w_bitIn && w_wuLast) begin
                        r_state <= ST_COLLECT;
                        r_wuCnt <= '0;
                    end else if (!i_enable) begin
                        r_state  <= ST_IDLE;
                        r_trngEn <= 1'b0;
                    end else if (w_bitIn) begin
                        r_wuCnt <= r_wuCnt + 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (w_trip) begin
                        r_state      <= ST_FAIL;
                        r_healthFail <= 1'b1;
                        r_trngEn     <= 1'b0;
                        r_bitCnt     <= '0;
                    end else if (w_bitIn && w_wordLast) begin
                        r_shreg  <= {r_shreg[WORD_W-2:0], i_trng_bit};
                        r_bitCnt <= '0;
                        r_state  <= ST_WRITE;
                        r_trngEn <= 1'b0;
                    end else if (!i_enable) begin
                        r_state  <= ST_IDLE;
                        r_bitCnt <= '0;
                        r_trngEn <= 1'b0;
                    end else if (w_bitIn) begin
                        r_shreg  <= {r_shreg[WORD_W-2:0], i_trng_bit};
                        r_bitCnt <= r_bitCnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (w_wrAccept) begin
                        r_wordCount <= r_wordCount + 1'b1;
                        r_state     <= i_enable ? ST_COLLECT : ST_IDLE;
                        r_trngEn    <= i_enable;
                    end
                end
                ST_FAIL: begin
                    if (i_clear_fail) begin
                        r_state      <= ST_IDLE;
                        r_healthFail <= 1'b0;
                        r_wuCnt      <= '0;
                        r_bitCnt     <= '0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_trngEn <= 1'b0;
                end
            endcase
        end
    end

    assign o_trng_en      = r_trngEn;
    assign o_fifo_wr_en   = w_wrAccept;
    assign o_fifo_wr_data = r_shreg;
    assign o_health_fail  = r_healthFail;
    assign o_word_count   = r_wordCount;
    assign o_state        = r_state;

endmodule

// File: tb/tb_trng_flow_ctrl.sv
// Scoreboard bench for trng_flow_ctrl: a behavioural model predicts words and per-cycle status,
// and a separate monitor pops predicted words whenever the FIFO write strobe fires.
module tb_trng_flow_ctrl;

    localparam int WORD_W      = 32;
    localparam int WARMUP_BITS = 64;
    localparam int RCT_LIMIT   = 34;
    localparam int CNT_W       = 16;

    localparam int M_IDLE = 0;
    localparam int M_WARM = 1;
    localparam int M_COLL = 2;
    localparam int M_WR   = 3;
    localparam int M_FAIL = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_enable;
    logic              i_clear_fail;
    logic              i_trng_bit;
    logic              i_trng_bit_valid;
    logic              o_trng_en;
    logic              i_fifo_full;
    logic              o_fifo_wr_en;
    logic [WORD_W-1:0] o_fifo_wr_data;
    logic              o_health_fail;
    logic [CNT_W-1:0]  o_word_count;
    logic [2:0]        o_state;

    always #5 clk = ~clk;

    trng_flow_ctrl #(
        .WORD_W      (WORD_W),
        .WARMUP_BITS (WARMUP_BITS),
        .RCT_LIMIT   (RCT_LIMIT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_enable         (i_enable),
        .i_clear_fail     (i_clear_fail),
        .i_trng_bit       (i_trng_bit),
        .i_trng_bit_valid (i_trng_bit_valid),
        .o_trng_en        (o_trng_en),
        .i_fifo_full      (i_fifo_full),
        .o_fifo_wr_en     (o_fifo_wr_en),
        .o_fifo_wr_data   (o_fifo_wr_data),
        .o_health_fail    (o_health_fail),
        .o_word_count     (o_word_count),
        .o_state          (o_state)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: mode of operation, counts, and the bits gathered for the next word.
    int                mode;
    int                warmCnt;
    int                run;
    bit                lastBit;
    bit                bitsQ[$];
    logic [WORD_W-1:0] expQ[$];
    logic [WORD_W-1:0] pendWord;
    int                wc;
    bit                health;

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WORD_W-1:0] packBits();
        logic [WORD_W-1:0] w = '0;
        foreach (bitsQ[i]) w = (w << 1) | WORD_W'(bitsQ[i]);
        return w;
    endfunction

    task automatic modelReset();
        mode    = M_IDLE;
        warmCnt = 0;
        run     = 0;
        lastBit = 1'b0;
        bitsQ.delete();
        expQ.delete();
        pendWord = '0;
        wc      = 0;
        health  = 1'b0;
    endtask

    task automatic modelStep(input bit en, input bit clr, input bit b, input bit v, input bit full);
        bit trip;
        case (mode)
            M_IDLE: begin
                if (en) begin
                    mode    = M_WARM;
                    warmCnt = 0;
                    run     = 0;
                    bitsQ.delete();
                end
            end
            M_WARM, M_COLL: begin
                trip = 1'b0;
                if (v) begin
                    if (run > 0 && b == lastBit) run = (run < 65535) ? run + 1 : run;
                    else run = 1;
                    lastBit = b;
                    trip = (run >= RCT_LIMIT);
                end
                if (trip) begin
                    mode   = M_FAIL;
                    health = 1'b1;
                    bitsQ.delete();
                end else if (mode == M_WARM) begin
                    if (v && warmCnt + 1 == WARMUP_BITS) mode = M_COLL;
                    else if (!en) mode = M_IDLE;
                    else if (v) warmCnt++;
                end else begin
                    if (v) bitsQ.push_back(b);
                    if (bitsQ.size() == WORD_W) begin
                        pendWord = packBits();
                        expQ.push_back(pendWord);
                        bitsQ.delete();
                        mode = M_WR;
                    end else if (!en) begin
                        bitsQ.delete();
                        mode = M_IDLE;
                    end
                end
            end
            M_WR: begin
                if (!full) begin
                    wc   = (wc + 1) % (1 << CNT_W);
                    mode = en ? M_COLL : M_IDLE;
                end
            end
            M_FAIL: begin
                if (clr) begin
                    mode   = M_IDLE;
                    health = 1'b0;
                end
            end
            default: mode = M_IDLE;
        endcase
    endtask

    task automatic checkOutput();
        compare("state", 64'(o_state), 64'(mode));
        compare("health_fail", 64'(o_health_fail), 64'(health));
        compare("trng_en", 64'(o_trng_en), 64'(mode == M_WARM || mode == M_COLL));
        compare("word_count", 64'(o_word_count), 64'(wc));
        compare("wr_en", 64'(o_fifo_wr_en), 64'(mode == M_WR && !i_fifo_full));
        if (mode == M_WR) compare("wr_data_hold", 64'(o_fifo_wr_data), 64'(pendWord));
    endtask

    // One clock cycle: drive inputs after the edge, check mid-cycle, then advance the model.
    task automatic applyStimulus(input bit en, input bit clr, input bit b, input bit v, input bit full);
        @(posedge clk);
        #2;
        i_enable         = en;
        i_clear_fail     = clr;
        i_trng_bit       = b;
        i_trng_bit_valid = v;
        i_fifo_full      = full;
        @(negedge clk);
        checkOutput();
        modelStep(en, clr, b, v, full);
    endtask

    task automatic warmupAlternating(input bit full);
        for (int i = 0; i < WARMUP_BITS; i++) applyStimulus(1'b1, 1'b0, bit'(i % 2), 1'b1, full);
    endtask

    // Monitor: every accepted write must match the oldest predicted word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && o_fifo_wr_en === 1'b1) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_write: got data %0h expected no write at %0t",
                             o_fifo_wr_data, $time);
                end else begin
                    compare("fifo_word", 64'(o_fifo_wr_data), 64'(expQ.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WORD_W-1:0] pattern;
        bit                bias;

        rst              = 1'b1;
        i_enable         = 1'b0;
        i_clear_fail     = 1'b0;
        i_trng_bit       = 1'b0;
        i_trng_bit_valid = 1'b0;
        i_fifo_full      = 1'b0;
        modelReset();
        #12;
        checkOutput();
        compare("reset_wr_data", 64'(o_fifo_wr_data), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] warm-up then 0xA5A5A5A5");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        warmupAlternating(1'b0);
        pattern = 32'hA5A5A5A5;
        for (int i = WORD_W - 1; i >= 0; i--) applyStimulus(1'b1, 1'b0, pattern[i], 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        compare("first_word_count", 64'(o_word_count), 64'(1));

        $display("[TB] back-pressure while in WRITE");
        pattern = 32'h3C96_5AC3;
        for (int i = WORD_W - 1; i >= 0; i--) applyStimulus(1'b1, 1'b0, pattern[i], 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, bit'($urandom_range(0, 1)), 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, bit'(i % 3 == 0), 1'b1, 1'b0);

        $display("[TB] repetition run of ones");
        for (int i = 0; i < RCT_LIMIT; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        compare("rct_health_flag", 64'(o_health_fail), 64'(1));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] enable drop mid-word");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        warmupAlternating(1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, bit'(i % 2), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WARMUP_BITS - 1; i++) applyStimulus(1'b1, 1'b0, bit'(i % 2), 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < WORD_W; i++) applyStimulus(1'b1, 1'b0, bit'(i % 2), 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] trip coincides with last packed bit");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WARMUP_BITS; i++)
            applyStimulus(1'b1, 1'b0, (i >= WARMUP_BITS - 2) ? 1'b0 : bit'(i % 2), 1'b1, 1'b0);
        for (int i = 0; i < WORD_W; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        compare("coincide_state", 64'(o_state), 64'(M_FAIL));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset during stalled WRITE");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        warmupAlternating(1'b1);
        for (int i = 0; i < WORD_W; i++) applyStimulus(1'b1, 1'b0, bit'(i % 2), 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        compare("rst_wr_en", 64'(o_fifo_wr_en), 64'(0));
        compare("rst_trng_en", 64'(o_trng_en), 64'(0));
        compare("rst_state", 64'(o_state), 64'(M_IDLE));
        compare("rst_wr_data", 64'(o_fifo_wr_data), 64'(0));
        compare("rst_word_count", 64'(o_word_count), 64'(0));
        compare("rst_health", 64'(o_health_fail), 64'(0));
        modelReset();
        i_enable    = 1'b0;
        i_fifo_full = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 4000; c++) begin
            bias = ((c / 150) % 2) == 1;
            applyStimulus(bit'($urandom_range(0, 199) != 0),
                          bit'($urandom_range(0, 19) == 0),
                          bias ? bit'($urandom_range(0, 49) != 0) : bit'($urandom_range(0, 1)),
                          bit'($urandom_range(0, 3) != 0),
                          bit'($urandom_range(0, 2) == 0));
        end
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        compare("leftover_words", 64'(expQ.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
